// File: rtl/mem_stage.sv
// mem_stage: RV64 memory-access pipeline stage.
//
// Takes the execute-stage result (effective address or plain result) and
// either passes it straight to writeback, reports a misaligned access, or
// performs a load/store over the data bus. It emits one registered
// writeback record per accepted instruction. Load data is aligned and
// sign- or zero-extended.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid            : execute result valid
//   in_addr             : ALU result (effective address or writeback data)
//   in_wdata            : store data (rs2)
//   in_op               : 0 NONE, 1..7 loads, 8..11 stores, 12..15 NONE
//   in_rd, in_pc        : passed through to the writeback record
//   flush               : discard current/pending instruction
//   stall               : upstream must hold its inputs (state is WAIT)
//   dreq_*              : data-bus request (valid, addr, size, strobe, data)
//   dresp_data_ok/_data : data-bus response
//   out_*               : writeback record, out_valid is a one-cycle pulse
//
// Bus handshake: dreq_valid rises at the edge that accepts an aligned memory
// op. From then on all dreq_* fields are held stable. The access completes
// at the first rising edge where dresp_data_ok is high while dreq_valid is
// high, and dreq_valid drops at that same edge. dresp_data_ok is ignored
// outside an outstanding request, and a request cannot be withdrawn except
// by reset.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [63:0] in_pc,
    input  logic        flush,
    output logic        stall,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [2:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic [4:0]  out_rd,
    output logic [63:0] out_pc,
    output logic        out_misalign
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state;
    logic [3:0]  lat_op;
    logic [4:0]  lat_rd;
    logic [63:0] lat_pc;
    logic        flushed;

    // Decode of the incoming op
    logic       in_is_mem;
    logic       in_is_store;
    logic [1:0] in_size;
    logic       in_misalign;
    logic [7:0] in_strobe_base;

    always_comb begin
        in_is_mem   = (in_op >= 4'd1) && (in_op <= 4'd11);
        in_is_store = (in_op >= 4'd8) && (in_op <= 4'd11);
        case (in_op)
            4'd1, 4'd5, 4'd8:  in_size = 2'd0;
            4'd2, 4'd6, 4'd9:  in_size = 2'd1;
            4'd3, 4'd7, 4'd10: in_size = 2'd2;
            default:           in_size = 2'd3;
        endcase
        case (in_size)
            2'd1:    in_misalign = in_addr[0];
            2'd2:    in_misalign = |in_addr[1:0];
            2'd3:    in_misalign = |in_addr[2:0];
            default: in_misalign = 1'b0;
        endcase
        case (in_size)
            2'd0:    in_strobe_base = 8'h01;
            2'd1:    in_strobe_base = 8'h03;
            2'd2:    in_strobe_base = 8'h0F;
            default: in_strobe_base = 8'hFF;
        endcase
    end

    // Load alignment uses the held request address (stable through WAIT).
    logic [63:0] load_raw;
    logic [63:0] load_result;

    always_comb begin
        load_raw = dresp_data >> {dreq_addr[2:0], 3'b000};
        case (lat_op)
            4'd1:    load_result = {{56{load_raw[7]}},  load_raw[7:0]};
            4'd2:    load_result = {{48{load_raw[15]}}, load_raw[15:0]};
            4'd3:    load_result = {{32{load_raw[31]}}, load_raw[31:0]};
            4'd5:    load_result = {56'd0, load_raw[7:0]};
            4'd6:    load_result = {48'd0, load_raw[15:0]};
            4'd7:    load_result = {32'd0, load_raw[31:0]};
            4'd4:    load_result = load_raw;
            default: load_result = 64'd0;   // stores write back zero
        endcase
    end

    assign stall = (state == S_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            lat_op       <= 4'd0;
            lat_rd       <= 5'd0;
            lat_pc       <= 64'd0;
            flushed      <= 1'b0;
            dreq_valid   <= 1'b0;
            dreq_addr    <= 64'd0;
            dreq_size    <= 3'd0;
            dreq_strobe  <= 8'd0;
            dreq_data    <= 64'd0;
            out_valid    <= 1'b0;
            out_data     <= 64'd0;
            out_rd       <= 5'd0;
            out_pc       <= 64'd0;
            out_misalign <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        lat_op <= in_op;
                        lat_rd <= in_rd;
                        lat_pc <= in_pc;
                        if (in_is_mem && !in_misalign) begin
                            state       <= S_WAIT;
                            flushed     <= 1'b0;
                            dreq_valid  <= 1'b1;
                            dreq_addr   <= in_addr;
                            dreq_size   <= {1'b0, in_size};
                            dreq_strobe <= in_is_store ? (in_strobe_base << in_addr[2:0]) : 8'd0;
                            dreq_data   <= in_is_store ? (in_wdata << {in_addr[2:0], 3'b000}) : 64'd0;
                        end else begin
                            // NONE passes the ALU result; a misaligned access
                            // reports the faulting address with no bus traffic.
                            out_valid    <= 1'b1;
                            out_data     <= in_addr;
                            out_rd       <= in_rd;
                            out_pc       <= in_pc;
                            out_misalign <= in_is_mem;
                        end
                    end
                end
                S_WAIT: begin
                    if (flush)
                        flushed <= 1'b1;
                    if (dresp_data_ok) begin
                        state      <= S_IDLE;
                        dreq_valid <= 1'b0;
                        // A flush on the completing edge also discards it.
                        if (!(flushed || flush)) begin
                            out_valid    <= 1'b1;
                            out_data     <= load_result;
                            out_rd       <= lat_rd;
                            out_pc       <= lat_pc;
                            out_misalign <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic [63:0] in_pc;
    logic        flush;
    logic        stall;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        out_valid;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic [63:0] out_pc;
    logic        out_misalign;

    int errors = 0;
    int checks = 0;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    mem_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_op        (in_op),
        .in_rd        (in_rd),
        .in_pc        (in_pc),
        .flush        (flush),
        .stall        (stall),
        .dreq_valid   (dreq_valid),
        .dreq_addr    (dreq_addr),
        .dreq_size    (dreq_size),
        .dreq_strobe  (dreq_strobe),
        .dreq_data    (dreq_data),
        .dresp_data_ok(dresp_data_ok),
        .dresp_data   (dresp_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_rd       (out_rd),
        .out_pc       (out_pc),
        .out_misalign (out_misalign)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [4:0] rd, input logic [63:0] pc);
        in_valid = v;
        in_op    = op;
        in_addr  = addr;
        in_wdata = wdata;
        in_rd    = rd;
        in_pc    = pc;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_op    = 4'd0;
    endtask

    // comparison point
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data = 64'd0;
        drive(1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 64'd0);
        tick();
        tick();

        // reset state
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_strobe", {56'd0, dreq_strobe}, 64'd0);
        reset = 1'b0;

        // NONE op, three back-to-back accepts
        drive(1'b1, 4'd0, 64'h1234, 64'd0, 5'd7, 64'h100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("none_out_valid", {63'd0, out_valid}, 64'd1);
            chk("none_out_data", out_data, 64'h1234);
            chk("none_stall", {63'd0, stall}, 64'd0);
        end
        chk("none_out_rd", {59'd0, out_rd}, 64'd7);
        chk("none_out_pc", out_pc, 64'h100);
        idle_in();
        tick();
        chk("none_pulse_end", {63'd0, out_valid}, 64'd0);

        // LBU at 0x8003, response two cycles after accept
        drive(1'b1, 4'd5, 64'h8003, 64'd0, 5'd3, 64'h200);
        tick();
        idle_in();
        chk("lbu_dreq_valid", {63'd0, dreq_valid}, 64'd1);
        chk("lbu_dreq_addr", dreq_addr, 64'h8003);
        chk("lbu_dreq_size", {61'd0, dreq_size}, 64'd0);
        chk("lbu_strobe", {56'd0, dreq_strobe}, 64'd0);
        chk("lbu_stall", {63'd0, stall}, 64'd1);
        chk("lbu_no_out", {63'd0, out_valid}, 64'd0);
        tick();
        chk("lbu_hold_valid", {63'd0, dreq_valid}, 64'd1);
        dresp_data_ok = 1'b1;
        dresp_data = 64'h00000000_80FF0000;
        tick();
        dresp_data_ok = 1'b0;
        chk("lbu_out_valid", {63'd0, out_valid}, 64'd1);
        chk("lbu_out_data", out_data, 64'h80);
        chk("lbu_out_rd", {59'd0, out_rd}, 64'd3);
        chk("lbu_out_pc", out_pc, 64'h200);
        chk("lbu_stall_low", {63'd0, stall}, 64'd0);
        chk("lbu_dreq_drop", {63'd0, dreq_valid}, 64'd0);
        tick();
        chk("lbu_pulse_end", {63'd0, out_valid}, 64'd0);
        chk("lbu_data_held", out_data, 64'h80);

        // LB at 0x8002 (0xFF sign-extended)
        drive(1'b1, 4'd1, 64'h8002, 64'd0, 5'd4, 64'h204);
        tick();
        idle_in();
        tick();
        dresp_data_ok = 1'b1;
        tick();
        dresp_data_ok = 1'b0;
        chk("lb_out_valid", {63'd0, out_valid}, 64'd1);
        chk("lb_out_data", out_data, 64'hFFFF_FFFF_FFFF_FFFF);

        // LW at 0x0 sign-extends bit 31; LWU at 0x4 zero-extends
        dresp_data = 64'h89ABCDEF_80000000;
        drive(1'b1, 4'd3, 64'h0, 64'd0, 5'd5, 64'h208);
        tick();
        idle_in();
        chk("lw_dreq_size", {61'd0, dreq_size}, 64'd2);
        dresp_data_ok = 1'b1;
        tick();
        dresp_data_ok = 1'b0;
        chk("lw_out_data", out_data, 64'hFFFF_FFFF_8000_0000);
        drive(1'b1, 4'd7, 64'h4, 64'd0, 5'd6, 64'h20C);
        tick();
        idle_in();
        dresp_data_ok = 1'b1;
        tick();
        dresp_data_ok = 1'b0;
        chk("lwu_out_data", out_data, 64'h0000_0000_89AB_CDEF);

        // SH at 0x10006, request held four cycles
        drive(1'b1, 4'd9, 64'h10006, 64'hABCD, 5'd0, 64'h300);
        tick();
        idle_in();
        chk("sh_strobe", {56'd0, dreq_strobe}, 64'hC0);
        chk("sh_dreq_data", dreq_data, 64'hABCD_0000_0000_0000);
        chk("sh_dreq_size", {61'd0, dreq_size}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sh_hold_valid", {63'd0, dreq_valid}, 64'd1);
            chk("sh_hold_data", dreq_data, 64'hABCD_0000_0000_0000);
        end
        dresp_data_ok = 1'b1;
        tick();
        dresp_data_ok = 1'b0;
        chk("sh_out_valid", {63'd0, out_valid}, 64'd1);
        chk("sh_out_data", out_data, 64'd0);

        // SD at 0x20: full strobe, unshifted data
        drive(1'b1, 4'd11, 64'h20, 64'h0123_4567_89AB_CDEF, 5'd0, 64'h304);
        tick();
        idle_in();
        chk("sd_strobe", {56'd0, dreq_strobe}, 64'hFF);
        chk("sd_dreq_data", dreq_data, 64'h0123_4567_89AB_CDEF);
        chk("sd_dreq_size", {61'd0, dreq_size}, 64'd3);
        dresp_data_ok = 1'b1;
        tick();
        dresp_data_ok = 1'b0;

        // Misaligned LW at 0x1002
        drive(1'b1, 4'd3, 64'h1002, 64'd0, 5'd9, 64'h400);
        tick();
        idle_in();
        chk("mis_lw_dreq", {63'd0, dreq_valid}, 64'd0);
        chk("mis_lw_out_valid", {63'd0, out_valid}, 64'd1);
        chk("mis_lw_flag", {63'd0, out_misalign}, 64'd1);
        chk("mis_lw_out_data", out_data, 64'h1002);
        chk("mis_lw_stall", {63'd0, stall}, 64'd0);
        // LD at 0x1004 is word-aligned but not doubleword-aligned
        drive(1'b1, 4'd4, 64'h1004, 64'd0, 5'd9, 64'h404);
        tick();
        idle_in();
        chk("mis_ld_flag", {63'd0, out_misalign}, 64'd1);
        chk("mis_ld_dreq", {63'd0, dreq_valid}, 64'd0);

        // dresp_data_ok in IDLE is ignored
        dresp_data_ok = 1'b1;
        tick();
        dresp_data_ok = 1'b0;
        chk("idle_ok_ignored", {63'd0, out_valid}, 64'd0);

        // Flush in IDLE: not accepted
        drive(1'b1, 4'd0, 64'h99, 64'd0, 5'd1, 64'h500);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_in();
        chk("flush_idle_no_out", {63'd0, out_valid}, 64'd0);
        chk("flush_idle_stall", {63'd0, stall}, 64'd0);

        // Flush in WAIT: request stays up, completion is silent
        drive(1'b1, 4'd4, 64'h40, 64'd0, 5'd2, 64'h600);
        tick();
        idle_in();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_wait_dreq", {63'd0, dreq_valid}, 64'd1);
        tick();
        tick();
        chk("flush_wait_dreq2", {63'd0, dreq_valid}, 64'd1);
        dresp_data_ok = 1'b1;
        tick();
        dresp_data_ok = 1'b0;
        chk("flush_wait_no_out", {63'd0, out_valid}, 64'd0);
        chk("flush_wait_stall", {63'd0, stall}, 64'd0);
        drive(1'b1, 4'd0, 64'h55, 64'd0, 5'd2, 64'h604);
        tick();
        idle_in();
        chk("after_flush_valid", {63'd0, out_valid}, 64'd1);
        chk("after_flush_data", out_data, 64'h55);

        // Reset mid-WAIT
        drive(1'b1, 4'd1, 64'h9000, 64'd0, 5'd8, 64'h700);
        tick();
        idle_in();
        chk("rstw_dreq_before", {63'd0, dreq_valid}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstw_dreq", {63'd0, dreq_valid}, 64'd0);
        chk("rstw_stall", {63'd0, stall}, 64'd0);
        chk("rstw_out_valid", {63'd0, out_valid}, 64'd0);
        tick();
        reset = 1'b0;
        drive(1'b1, 4'd0, 64'h77, 64'd0, 5'd1, 64'h800);
        tick();
        idle_in();
        chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
        chk("post_rst_data", out_data, 64'h77);
        chk("post_rst_misalign", {63'd0, out_misalign}, 64'd0);
        tick();

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage for the RV64 core, sitting directly downstream of the execute-stage ALU. It consumes the ALU result (an effective address or a plain result), performs loads and stores over the data-bus request/response handshake, and aligns and sign- or zero-extends load data. It emits one registered writeback record per accepted instruction. It holds the upstream pipeline via `stall` while a bus access is outstanding.

## Interface
- No parameters. XLEN is fixed at 64.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: execute result valid, i.e. ALU not bubbling.
- `in_addr` in 64: ALU result; the effective address for memory ops, otherwise the writeback data.
- `in_wdata` in 64: store data (rs2).
- `in_op` in 4: memory op code.
  - 0 NONE, 1 LB, 2 LH, 3 LW, 4 LD, 5 LBU, 6 LHU, 7 LWU
  - 8 SB, 9 SH, 10 SW, 11 SD
  - 12–15 are treated as NONE.
- `in_rd` in 5, `in_pc` in 64: passed through to the output.
- `flush` in 1: discard the current and pending instruction.
- `stall` out 1: upstream must hold its inputs.
- `dreq_valid` out 1, `dreq_addr` out 64, `dreq_size` out 3 (log2 bytes), `dreq_strobe` out 8, `dreq_data` out 64.
- `dresp_data_ok` in 1, `dresp_data` in 64.
- `out_valid` out 1, `out_data` out 64, `out_rd` out 5, `out_pc` out 64, `out_misalign` out 1.

## Operation
- **States:** IDLE and WAIT.
- **Accept:** an instruction is accepted at a rising edge when state is IDLE, `in_valid` is 1 and `flush` is 0. Address, op, wdata, rd and pc are latched internally at accept.
- **NONE op:** stays in IDLE. Next cycle: `out_valid`=1, `out_data`=`in_addr`, `out_misalign`=0.
- **Misalignment:** an access is misaligned when
  - H-ops have `addr[0]`≠0, or
  - W-ops have `addr[1:0]`≠0, or
  - D-ops have `addr[2:0]`≠0.
  A misaligned access issues no bus request. Next cycle: `out_valid`=1, `out_misalign`=1, `out_data`=faulting address.
- **Aligned memory op:** go to WAIT.
  - `dreq_valid`=1 with `dreq_addr`=latched address and `dreq_size` = 0, 1, 2 or 3 for B, H, W, D.
  - Request fields are held stable until `dresp_data_ok`.
- **Stores:**
  - `dreq_data` = wdata << (8·`addr[2:0]`).
  - `dreq_strobe` = (0x01, 0x03, 0x0F or 0xFF) << `addr[2:0]`.
  - Load: `dreq_strobe`=0.
  - Store: `out_data`=0.
- **Loads:**
  - Compute raw = `dresp_data` >> (8·`addr[2:0]`), truncated to the access size.
  - LB, LH, LW sign-extend; LBU, LHU, LWU zero-extend; LD passes through.
- **`dresp_data_ok` in WAIT:** return to IDLE. Next cycle: `out_valid`=1 with the result, unless the instruction was flushed.
- **`flush`:**
  - In IDLE: the instruction is not accepted. Any `out_valid` that would appear next cycle is suppressed.
  - In WAIT: the bus request cannot be aborted. `dreq_valid` stays high until `dresp_data_ok`, a flushed flag is set, and completion produces no `out_valid`.
- **`stall`:** `stall` = (state==WAIT), combinational from state.

## Timing
- **Reset values:** all outputs 0, state IDLE, flushed flag 0. Reset mid-WAIT drops `dreq_valid` immediately (asynchronously) and loses the instruction.
- **NONE / misaligned latency:** 1 cycle. Back-to-back accepts every cycle give `out_valid` every cycle.
- **Memory op:**
  - Accept at edge E0; `dreq_valid` is high after E0.
  - `dresp_data_ok` sampled at edge Ek (k≥1).
  - `out_valid` is high for exactly one cycle after Ek.
  - `stall` is high from E0 to Ek; the next accept is possible at Ek+1.
- **`dresp_data_ok` outside WAIT:** ignored.
- **`out_valid`:** a one-cycle pulse per completed instruction. `out_*` other than `out_valid` hold their last value otherwise.

## Test plan
- **NONE op:** `in_op`=0, `in_addr`=0x1234 for 3 consecutive cycles -> `out_valid` for 3 consecutive cycles, `out_data`=0x1234, `stall` never high.
- **LB:** addr 0x8003, `dresp_data_ok` after 2 cycles with `dresp_data`=0x00000000_80FF0000 -> `dreq_size`=0, `out_data`=0x0000000000000080 for LBU. For LB from the same data with addr 0x8002: `out_data`=0xFFFFFFFFFFFFFFFF.
- **SH:** addr 0x10006, wdata 0xABCD -> `dreq_strobe`=0xC0, `dreq_data`=0xABCD000000000000, `dreq_size`=1, request held 4 cycles until `dresp_data_ok`.
- **Misaligned LW:** addr 0x1002 -> no `dreq_valid`; next cycle `out_misalign`=1, `out_data`=0x1002.
- **Flush in WAIT:** LD in WAIT, `flush` pulsed, `dresp_data_ok` 3 cycles later -> `dreq_valid` held through `dresp_data_ok`, no `out_valid`; a new accept succeeds on the following edge.
- **Reset mid-WAIT:** `reset` asserted mid-WAIT -> `dreq_valid`, `stall`, `out_valid` all 0 immediately. After release, a NONE op completes normally.
